// File: rtl/cam_table_client_if.sv
// Handshake bundle between cam_table_client, its command/response stage and the EP2 CAM table.
// The master modport is the client; slave is the environment (pipeline stage plus table).
interface cam_table_client_if #(
  parameter int KEY_SIZE   = 8,
  parameter int VALUE_SIZE = 32,
  parameter int USER_WIDTH = 4
);
  logic [1:0]            cmd_op;
  logic [KEY_SIZE-1:0]   cmd_key;
  logic [VALUE_SIZE-1:0] cmd_operand;
  logic [USER_WIDTH-1:0] cmd_user;
  logic                  cmd_valid;
  logic                  cmd_ready;

  logic [KEY_SIZE-1:0]   lookup_req_index;
  logic [USER_WIDTH-1:0] lookup_req_user;
  logic                  lookup_req_valid;
  logic                  lookup_req_ready;

  logic [VALUE_SIZE-1:0] lookup_value_data;
  logic                  lookup_value_valid;
  logic                  lookup_value_ready;

  logic [KEY_SIZE-1:0]   update_req_index;
  logic [VALUE_SIZE-1:0] update_req_data;
  logic [USER_WIDTH-1:0] update_req_user;
  logic                  update_req_valid;
  logic                  update_req_ready;

  logic [VALUE_SIZE-1:0] resp_data;
  logic [USER_WIDTH-1:0] resp_user;
  logic                  resp_err;
  logic                  resp_valid;
  logic                  resp_ready;

  modport master (
    input  cmd_op, cmd_key, cmd_operand, cmd_user, cmd_valid,
    output cmd_ready,
    output lookup_req_index, lookup_req_user, lookup_req_valid,
    input  lookup_req_ready,
    input  lookup_value_data, lookup_value_valid,
    output lookup_value_ready,
    output update_req_index, update_req_data, update_req_user, update_req_valid,
    input  update_req_ready,
    output resp_data, resp_user, resp_err, resp_valid,
    input  resp_ready
  );

  modport slave (
    output cmd_op, cmd_key, cmd_operand, cmd_user, cmd_valid,
    input  cmd_ready,
    input  lookup_req_index, lookup_req_user, lookup_req_valid,
    output lookup_req_ready,
    output lookup_value_data, lookup_value_valid,
    input  lookup_value_ready,
    input  update_req_index, update_req_data, update_req_user, update_req_valid,
    output update_req_ready,
    input  resp_data, resp_user, resp_err, resp_valid,
    output resp_ready
  );
endinterface

// File: rtl/cam_table_client.sv
// Single-outstanding initiator for the EP2 CAM table: READ, WRITE and atomic ADD
// (lookup then update with no other access in between), one response per command.
module cam_table_client #(
  parameter int KEY_SIZE       = 8,
  parameter int VALUE_SIZE     = 32,
  parameter int USER_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  cam_table_client_if.master bus,
  output logic [15:0]        stale_count
);

  typedef enum logic [2:0] {IDLE, LOOKUP, WAIT, UPDATE, RESP} state_t;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_ADD, OP_RSVD} op_t;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                state, state_n;
  op_t                   op_q;
  logic [VALUE_SIZE-1:0] operand_q;
  logic [15:0]           timer;

  assign bus.cmd_ready          = (state == IDLE) && !rst;
  assign bus.lookup_value_ready = ((state == IDLE) || (state == WAIT)) && !rst;

  // NOTE: state_n gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (bus.cmd_valid) begin
        unique case (op_t'(bus.cmd_op))
          OP_READ, OP_ADD: state_n = LOOKUP;
          OP_WRITE:        state_n = UPDATE;
          default:         state_n = RESP;
        endcase
      end
      LOOKUP: if (bus.lookup_req_ready) state_n = WAIT;
      // A value arriving on the last timer cycle beats the timeout.
      WAIT: begin
        if (bus.lookup_value_valid)  state_n = (op_q == OP_ADD) ? UPDATE : RESP;
        else if (timer == TIMER_LAST) state_n = RESP;
      end
      UPDATE: if (bus.update_req_ready) state_n = RESP;
      RESP:   if (bus.resp_ready)       state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: all state here uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      op_q                 <= OP_READ;
      operand_q            <= '0;
      timer                <= '0;
      stale_count          <= '0;
      bus.lookup_req_index <= '0;
      bus.lookup_req_user  <= '0;
      bus.lookup_req_valid <= 1'b0;
      bus.update_req_index <= '0;
      bus.update_req_data  <= '0;
      bus.update_req_user  <= '0;
      bus.update_req_valid <= 1'b0;
      bus.resp_data        <= '0;
      bus.resp_user        <= '0;
      bus.resp_err         <= 1'b0;
      bus.resp_valid       <= 1'b0;
    end else begin
      state                <= state_n;
      bus.lookup_req_valid <= (state_n == LOOKUP);
      bus.update_req_valid <= (state_n == UPDATE);
      bus.resp_valid       <= (state_n == RESP);

      // Values accepted while idle belong to an abandoned lookup.
      if (state == IDLE && bus.lookup_value_valid && stale_count != 16'hFFFF)
        stale_count <= stale_count + 16'd1;

      unique case (state)
        IDLE: if (bus.cmd_valid) begin
          op_q                 <= op_t'(bus.cmd_op);
          operand_q            <= bus.cmd_operand;
          bus.lookup_req_index <= bus.cmd_key;
          bus.update_req_index <= bus.cmd_key;
          bus.lookup_req_user  <= bus.cmd_user;
          bus.update_req_user  <= bus.cmd_user;
          bus.resp_user        <= bus.cmd_user;
          bus.update_req_data  <= bus.cmd_operand;
          bus.resp_data        <= (op_t'(bus.cmd_op) == OP_WRITE) ? bus.cmd_operand : '0;
          bus.resp_err         <= (op_t'(bus.cmd_op) == OP_RSVD);
        end
        LOOKUP: if (bus.lookup_req_ready) timer <= '0;
        WAIT: begin
          if (bus.lookup_value_valid) begin
            bus.resp_data       <= bus.lookup_value_data;
            bus.update_req_data <= bus.lookup_value_data + operand_q;
            bus.resp_err        <= 1'b0;
          end else if (timer == TIMER_LAST) begin
            bus.resp_data <= '0;
            bus.resp_err  <= 1'b1;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cam_table_client.md
# cam_table_client

- Initiator for the EP2 CAM key/value table. It takes one command at a time from a pipeline stage: read, write or atomic add.
- For each command it drives the table's lookup and update request channels and collects the lookup value. It then returns exactly one response per command.
- It sits between an event-handler stage and the table, and turns a read-modify-write into lookup → update with no other access from this client in between.

## Interface
Parameters:
- KEY_SIZE, 8, key width
- VALUE_SIZE, 32, value width
- USER_WIDTH, 4, command/response user width; also drives table request user fields
- TIMEOUT_CYCLES, 64, maximum WAIT cycles before the lookup is abandoned (≥1, ≤65535)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cmd_op  in  2  0=READ, 1=WRITE, 2=ADD, 3=reserved
- cmd_key  in  KEY_SIZE  table key
- cmd_operand  in  VALUE_SIZE  write value / addend
- cmd_user  in  USER_WIDTH  echoed on response
- cmd_valid / cmd_ready  in / out  1  command handshake
- lookup_req_index  out  KEY_SIZE  lookup key
- lookup_req_user  out  USER_WIDTH  = latched cmd_user
- lookup_req_valid / lookup_req_ready  out / in  1
- lookup_value_data  in  VALUE_SIZE  returned value
- lookup_value_valid / lookup_value_ready  in / out  1
- update_req_index  out  KEY_SIZE
- update_req_data  out  VALUE_SIZE
- update_req_user  out  USER_WIDTH
- update_req_valid / update_req_ready  out / in  1
- resp_data  out  VALUE_SIZE  result value
- resp_user  out  USER_WIDTH
- resp_err  out  1  timeout or reserved op
- resp_valid / resp_ready  out / in  1
- stale_count  out  16  lookup values dropped in IDLE, saturating

## Operation
- FSM states: IDLE, LOOKUP, WAIT, UPDATE, RESP.
- IDLE → on cmd_valid: latch op/key/operand/user.
  - READ/ADD → LOOKUP.
  - WRITE → UPDATE with data = operand.
  - reserved → RESP with err=1, data=0.
- LOOKUP: lookup_req_valid=1 with index/user stable. On handshake → WAIT and clear timer.
- WAIT: lookup_value_ready=1.
  - On lookup_value_valid, capture data.
  - READ → RESP with data=value.
  - ADD → UPDATE with update data = (value + operand) mod 2^VALUE_SIZE, truncated and carry discarded; resp_data = old value.
  - Timer increments each WAIT cycle without a value. When timer == TIMEOUT_CYCLES-1 and no value that cycle → RESP with err=1, data=0, no update.
- UPDATE: update_req_valid=1 with index/data/user stable. On handshake → RESP.
  - resp_data = operand for WRITE, old value for ADD.
- RESP: resp_valid=1 with fields stable. On resp_ready → IDLE.
- Stale lookup values:
  - lookup_value_ready is also 1 in IDLE. A value accepted in IDLE is discarded and increments stale_count, saturating at 0xFFFF.
  - lookup_value_ready is 0 in LOOKUP, UPDATE and RESP.
- A miss is not distinguished; whatever the table returns is used.

## Timing
- cmd_ready = (state==IDLE) && !rst.
- All valid outputs and data/index/user outputs are registered.
- Reset: state=IDLE; all valid outputs 0; resp_err=0; all data/index/user outputs 0; stale_count=0; timer=0.
- rst mid-transaction aborts immediately with no response. An outstanding table value arriving later is counted stale.
- Minimum latencies, cmd handshake at cycle 0:
  - WRITE: update_req_valid at cycle 1; handshake at cycle 1 with update_req_ready=1; resp_valid at cycle 2.
  - READ: lookup_req_valid at cycle 1; value valid at cycle N≥2; resp_valid at N+1.
  - ADD: update_req_valid at N+1; resp_valid at N+2.
- Back-to-back commands: the next cmd is accepted in the cycle after the resp handshake. There is no cmd_ready in the resp-handshake cycle itself.
- Valid is held until ready. Payload never changes while valid=1 and ready=0.
- Timeout and value arriving in the same cycle: the value wins.

## Test plan
- WRITE key=0x05 operand=0xDEADBEEF, update_req_ready=1 → update index 0x05 data 0xDEADBEEF at cycle 1; resp data 0xDEADBEEF err=0 at cycle 2.
- READ key=0x05, table returns 0x12345678 after 3 cycles, lookup_req_ready=1 → resp data 0x12345678, user echoed, err=0.
- ADD operand=0x00000002, table returns 0xFFFFFFFF → update data 0x00000001 (wrap); resp data 0xFFFFFFFF.
- READ with no lookup value, TIMEOUT_CYCLES=4 → resp err=1 data=0 after 4 WAIT cycles. Inject the value 2 cycles later in IDLE → stale_count=1, no extra resp.
- Backpressure: hold update_req_ready, lookup_req_ready and resp_ready at 0 for 5 cycles each → valids held, payload stable, cmd_ready=0 throughout.
- cmd_op=3 → resp err=1 at cycle 1 with no table traffic. rst asserted in WAIT → all valids 0 next cycle, cmd_ready=1 after rst deasserts.
